cbfp_index_tx: RTL and testbench

CBFP_INDEX_TX -- requirements
Module: cbfp_index_tx

---
 rtl/fft_cbfp_pkg.sv | 13 +
 rtl/cbfp_idx_ram.sv | 43 ++++
 rtl/cbfp_index_tx.sv | 128 ++++++++++++
 tb/tb_cbfp_index_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_cbfp_pkg.sv
// Shared constants and the index-vector type for the CBFP index path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_cbfp_pkg;

    localparam int N     = 16;   // index lanes per block, one per FFT lane
    localparam int IDX_W = 5;    // bits per CBFP shift index
    localparam int DEPTH = 32;   // buffered index vectors (power of two)

    // One block's worth of shift indices, lane 0 first.
    typedef logic [0:N-1][IDX_W-1:0] idx_vec_t;

endpackage

// File: rtl/cbfp_idx_ram.sv
// Index-vector storage: one write port, one registered read port.
// Latency: read data appears one clock after rd_en_i; write lands on the same edge.
// Backpressure: none; the controller only issues legal accesses.
module cbfp_idx_ram
    import fft_cbfp_pkg::*;
#(
    parameter int RAM_DEPTH = fft_cbfp_pkg::DEPTH,
    parameter int DAT_W     = fft_cbfp_pkg::N * fft_cbfp_pkg::IDX_W,
    parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DAT_W-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DAT_W-1:0]  rd_data_o
);

    logic [DAT_W-1:0] mem_q [RAM_DEPTH];
    logic [DAT_W-1:0] rd_data_q;

    // Array write; contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds the last read value; a same-address write in the
    // same cycle returns the old entry (needed when full with push+pop).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cbfp_index_tx.sv
// CBFP shift-index FIFO feeding the stage-2 pipeline; optional sticky error flags (CBFP_IDX_ERR_FLAGS_EN).
// Latency: popped vector and valid_out appear exactly one clock after an accepted rd_req.
// Backpressure: push dropped when full (unless a pop frees the slot), pop ignored when empty.
module cbfp_index_tx
    import fft_cbfp_pkg::*;
#(
    parameter int N     = fft_cbfp_pkg::N,
    parameter int IDX_W = fft_cbfp_pkg::IDX_W,
    parameter int DEPTH = fft_cbfp_pkg::DEPTH
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        wr_valid,
    input  logic [0:N-1][IDX_W-1:0]     wr_index,
    input  logic                        rd_req,
    input  logic                        err_clr,
    output logic [0:N-1][IDX_W-1:0]     index_out,
    output logic                        valid_out,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, empty_q, valid_q;
    logic               push_acc, pop_acc;
    logic [N*IDX_W-1:0] rd_data;

    // Accept decisions and next pointer/occupancy. When full, a pop in the
    // same cycle frees the slot, so the push is taken too.
    always_comb begin
        pop_acc  = rd_req && !empty_q;
        push_acc = wr_valid && (!full_q || pop_acc);
        wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_acc  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; full/empty are registered from the next occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            valid_q  <= pop_acc;
        end
    end

    cbfp_idx_ram #(
        .RAM_DEPTH (DEPTH),
        .DAT_W     (N * IDX_W),
        .ADDR_W    (PW)
    ) u_ram (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (push_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_index),
        .rd_en_i   (pop_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign index_out = rd_data;
    assign valid_out = valid_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;

`ifdef CBFP_IDX_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; a clear wins over a same-cycle error event.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_valid && !push_acc) overflow_d  = 1'b1;
            if (rd_req && !pop_acc)    underflow_d = 1'b1;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_cbfp_index_tx.sv
// Scoreboard bench for cbfp_index_tx: queue-based reference model, randomized and directed traffic.
// Latency: expectations target the clock edge following each driven cycle.
// Backpressure: model decides push/pop acceptance from occupancy alone.
module tb_cbfp_index_tx;
    import fft_cbfp_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef CBFP_IDX_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_valid, rd_req, err_clr;
    idx_vec_t      wr_index, index_out;
    logic          valid_out, full, empty, overflow, underflow;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    cbfp_index_tx dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_valid  (wr_valid),
        .wr_index  (wr_index),
        .rd_req    (rd_req),
        .err_clr   (err_clr),
        .index_out (index_out),
        .valid_out (valid_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    typedef struct {
        int cnt;
        bit vld;
        bit ovf;
        bit udf;
    } stat_t;

    stat_t    exp_st_q[$];
    idx_vec_t exp_dat_q[$];
    idx_vec_t mq[$];          // reference FIFO contents
    bit       m_ovf, m_udf;
    int       n_cmp = 0;
    int       n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic idx_vec_t rand_vec();
        idx_vec_t v;
        for (int k = 0; k < N; k++) v[k] = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
        return v;
    endfunction

    function automatic idx_vec_t pat_vec(input int j);
        idx_vec_t v;
        for (int k = 0; k < N; k++) v[k] = IDX_W'(k + j);
        return v;
    endfunction

    // One cycle of stimulus: drive, advance the model, queue what the next edge must show.
    task automatic drive(input bit wv, input bit rr, input bit ec, input idx_vec_t v);
        int    sz;
        bit    pop_ok, push_ok;
        stat_t s;
        wr_valid = wv;
        rd_req   = rr;
        err_clr  = ec;
        wr_index = v;
        sz       = mq.size();
        pop_ok   = rr && (sz > 0);
        push_ok  = wv && ((sz < DEPTH) || pop_ok);
        if (pop_ok)  exp_dat_q.push_back(mq.pop_front());
        if (push_ok) mq.push_back(v);
        if (FLAGS_EN) begin
            if (ec) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (wv && !push_ok) m_ovf = 1'b1;
                if (rr && !pop_ok)  m_udf = 1'b1;
            end
        end
        s.cnt = mq.size();
        s.vld = pop_ok;
        s.ovf = m_ovf;
        s.udf = m_udf;
        exp_st_q.push_back(s);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    // Hold reset for ncyc edges; the model forgets everything buffered.
    task automatic do_reset(input int ncyc);
        stat_t s;
        rstn     = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        err_clr  = 1'b0;
        wr_index = '0;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        s.cnt = 0;
        s.vld = 1'b0;
        s.ovf = 1'b0;
        s.udf = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            exp_st_q.push_back(s);
            @(posedge clk);
            #2;
        end
        rstn = 1'b1;
    endtask

    // Monitor: one status expectation per edge, data expectation on each pop.
    initial begin
        stat_t    s;
        idx_vec_t d;
        idx_vec_t last;
        last = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) last = '0;
            if (exp_st_q.size() > 0) begin
                s = exp_st_q.pop_front();
                chk("count",     count,     s.cnt[CW-1:0]);
                chk("full",      full,      s.cnt == DEPTH);
                chk("empty",     empty,     s.cnt == 0);
                chk("valid_out", valid_out, s.vld);
                chk("overflow",  overflow,  s.ovf);
                chk("underflow", underflow, s.udf);
                if (s.vld) begin
                    if (exp_dat_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL data_queue: no expected vector for pop at %0t", $time);
                    end else begin
                        d = exp_dat_q.pop_front();
                        chk("index_out", index_out, d);
                        last = d;
                    end
                end else begin
                    chk("index_hold", index_out, last);
                end
            end
        end
    end

    initial begin
        int pw, pr;
        rstn     = 1'b1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        err_clr  = 1'b0;
        wr_index = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        #1 rstn = 1'b0;
        #2;
        chk("rst_count",     count,     0);
        chk("rst_empty",     empty,     1);
        chk("rst_full",      full,      0);
        chk("rst_valid",     valid_out, 0);
        chk("rst_index",     index_out, 0);
        chk("rst_overflow",  overflow,  0);
        chk("rst_underflow", underflow, 0);
        @(posedge clk);
        #2;
        do_reset(2);

        // Three patterned vectors, then three pops.
        for (int j = 0; j < 3; j++) drive(1'b1, 1'b0, 1'b0, pat_vec(j));
        for (int j = 0; j < 3; j++) drive(1'b0, 1'b1, 1'b0, '0);
        idle(2);

        // Fill past capacity, then drain past empty.
        for (int j = 0; j < DEPTH + 1; j++) drive(1'b1, 1'b0, 1'b0, rand_vec());
        for (int j = 0; j < DEPTH + 1; j++) drive(1'b0, 1'b1, 1'b0, '0);
        idle(1);

        // Pop while empty, then clear flags (including a clear racing an error).
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, '0);
        drive(1'b0, 1'b1, 1'b1, '0);
        idle(1);

        // Simultaneous push and pop held at full long enough to wrap pointers.
        for (int j = 0; j < DEPTH; j++) drive(1'b1, 1'b0, 1'b0, rand_vec());
        for (int j = 0; j < 40; j++)    drive(1'b1, 1'b1, 1'b0, rand_vec());
        for (int j = 0; j < DEPTH; j++) drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, rand_vec());
        drive(1'b0, 1'b1, 1'b0, '0);
        idle(1);

        // Reset with ten vectors buffered; only the fresh vector may come back.
        for (int j = 0; j < 10; j++) drive(1'b1, 1'b0, 1'b0, rand_vec());
        do_reset(2);
        drive(1'b1, 1'b0, 1'b0, rand_vec());
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, '0);
        idle(2);

        // Random traffic with varying push/pop pressure.
        for (int seg = 0; seg < 6; seg++) begin
            pw = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 999) == 0) begin
                    do_reset(1);
                end else begin
                    drive($urandom_range(0, 99) < pw,
                          $urandom_range(0, 99) < pr,
                          $urandom_range(0, 39) == 0,
                          rand_vec());
                end
            end
        end

        // Drain whatever is left and confirm nothing is outstanding.
        for (int i = 0; i < DEPTH + 2 && mq.size() > 0; i++) drive(1'b0, 1'b1, 1'b0, '0);
        idle(3);
        chk("status_backlog", exp_st_q.size(), 0);
        chk("data_backlog",   exp_dat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
